// File: rtl/fc8_audio_pkg.sv
// Shared types and field positions for the FC8 audio envelope path.
// Channel SFR bytes: vol_env = {vol[7:4], dir[3], per[2:0]}, ctrl = {.., loop[1], en[0]}.
package fc8_audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fsm_e;

    localparam logic [3:0] VOL_MAX = 4'hf;

    localparam int VOL_HI   = 7;
    localparam int VOL_LO   = 4;
    localparam int DIR_BIT  = 3;
    localparam int PER_HI   = 2;
    localparam int PER_LO   = 0;

    localparam int EN_BIT   = 0;
    localparam int LOOP_BIT = 1;

endpackage

// File: rtl/fc8_env_step.sv
// Combinational envelope step, shared by all channels through the
// scan mux in the top level.
module fc8_env_step #(
    parameter int VOL_W = 4
) (
    input  logic [VOL_W-1:0] vol,
    input  logic [2:0]       div,
    input  logic [2:0]       per,
    input  logic             dir,
    input  logic             loop,
    input  logic             done,
    output logic [VOL_W-1:0] vol_nxt,
    output logic [2:0]       div_nxt,
    output logic             done_nxt
);

    localparam logic [VOL_W-1:0] VMAX = '1;

    logic tick;

    always_comb begin
        vol_nxt  = vol;
        div_nxt  = div;
        done_nxt = done;
        tick     = ({1'b0, div} + 4'd1) == {1'b0, per};
        if (per == 3'd0) begin
            div_nxt = 3'd0;
        end else if (!tick) begin
            div_nxt = div + 3'd1;
        end else begin
            div_nxt = 3'd0;
            // a finished envelope keeps dividing but never moves again
            if (!done) begin
                if (dir) begin
                    if (vol != VMAX) vol_nxt = vol + VOL_W'(1);
                    else if (loop)   vol_nxt = '0;
                    else             done_nxt = 1'b1;
                end else begin
                    if (vol != '0)   vol_nxt = vol - VOL_W'(1);
                    else if (loop)   vol_nxt = VMAX;
                    else             done_nxt = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fc8_audio_env_scheduler.sv
// Frame-rate volume envelope scheduler: each VSYNC scans every channel,
// one per audio_clk, through a single shared step unit.
module fc8_audio_env_scheduler
    import fc8_audio_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int VOL_W  = 4
) (
    input  logic                    audio_clk,
    input  logic                    rst,
    input  logic                    vsync_pulse_in,
    input  logic [8*NUM_CH-1:0]     ch_vol_env_in,
    input  logic [8*NUM_CH-1:0]     ch_ctrl_in,
    input  logic [NUM_CH-1:0]       key_on_in,
    output logic [VOL_W*NUM_CH-1:0] ch_vol_out,
    output logic [NUM_CH-1:0]       env_done_out,
    output logic                    busy_out,
    output logic                    vsync_overrun_out
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);
    localparam int PER_W = PER_HI - PER_LO + 1;

    fsm_e             state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             pending, pending_nxt;
    logic             ovr, ovr_nxt;

    logic [VOL_W*NUM_CH-1:0] vol_flat;
    logic [3*NUM_CH-1:0]     div_flat;
    logic [NUM_CH-1:0]       done_flat;

    logic [VOL_W-1:0] s_vol, n_vol;
    logic [2:0]       s_div, n_div, s_per;
    logic             s_dir, s_loop, s_done, n_done;

    logic ctrl_unused;
    assign ctrl_unused = ^ch_ctrl_in;

    always_ff @(posedge audio_clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            ovr     <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        ovr_nxt     = ovr;
        unique case (state)
            IDLE: begin
                if (vsync_pulse_in || pending) begin
                    state_nxt   = SCAN;
                    idx_nxt     = '0;
                    pending_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (vsync_pulse_in) begin
                    if (pending) ovr_nxt = 1'b1;
                    else         pending_nxt = 1'b1;
                end
                // a queued frame restarts the scan with no idle gap
                if (idx == LAST) begin
                    idx_nxt = '0;
                    if (pending) pending_nxt = 1'b0;
                    else         state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_vol  = vol_flat[int'(idx)*VOL_W +: VOL_W];
        s_div  = div_flat[int'(idx)*3 +: 3];
        s_done = done_flat[idx];
        s_per  = ch_vol_env_in[int'(idx)*8 + PER_LO +: PER_W];
        s_dir  = ch_vol_env_in[int'(idx)*8 + DIR_BIT];
        s_loop = ch_ctrl_in[int'(idx)*8 + LOOP_BIT];
    end

    fc8_env_step #(
        .VOL_W (VOL_W)
    ) u_step (
        .vol      (s_vol),
        .div      (s_div),
        .per      (s_per),
        .dir      (s_dir),
        .loop     (s_loop),
        .done     (s_done),
        .vol_nxt  (n_vol),
        .div_nxt  (n_div),
        .done_nxt (n_done)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [VOL_W-1:0] vol_q;
        logic [2:0]       div_q;
        logic             done_q;
        logic             en, hit;

        assign en  = ch_ctrl_in[8*i + EN_BIT];
        assign hit = (state == SCAN) && (idx == IDX_W'(i));

        always_ff @(posedge audio_clk) begin
            if (rst) begin
                vol_q  <= '0;
                div_q  <= '0;
                done_q <= 1'b0;
            end else if (!en) begin
                vol_q <= '0;
                div_q <= '0;
            end else if (key_on_in[i]) begin
                vol_q  <= VOL_W'(ch_vol_env_in[8*i + VOL_LO +: VOL_HI - VOL_LO + 1]);
                div_q  <= '0;
                done_q <= 1'b0;
            end else if (hit) begin
                vol_q  <= n_vol;
                div_q  <= n_div;
                done_q <= n_done;
            end
        end

        assign vol_flat[VOL_W*i +: VOL_W] = vol_q;
        assign div_flat[3*i +: 3]         = div_q;
        assign done_flat[i]               = done_q;
    end

    assign ch_vol_out        = vol_flat;
    assign env_done_out      = done_flat;
    assign busy_out          = (state == SCAN);
    assign vsync_overrun_out = ovr;

endmodule
